// File: rtl/uart_mmio_ram.sv
// Word-addressed single-port RAM used as the memory target of the UART
// memory-mapped controller. The controller writes with one-cycle strobes.
// The controller reads with a held request and gets a fixed-latency
// completion pulse. A lower-priority host port shares the same array.
// Priority on the array each cycle: controller write, then controller read
// accept, then host grant.
module uart_mmio_ram #(
    parameter int NUM_BYTES_DATA    = 4,
    parameter int NUM_BYTES_ADDRESS = 1,
    parameter int READ_LATENCY      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem_we,
    input  logic [8*NUM_BYTES_DATA-1:0]    mem_wdata,
    input  logic [8*NUM_BYTES_ADDRESS-1:0] mem_waddr,
    input  logic                           mem_re,
    input  logic [8*NUM_BYTES_ADDRESS-1:0] mem_raddr,
    output logic [8*NUM_BYTES_DATA-1:0]    mem_rdata,
    output logic                           mem_rdy,
    input  logic                           host_req,
    input  logic                           host_we,
    input  logic [8*NUM_BYTES_ADDRESS-1:0] host_addr,
    input  logic [8*NUM_BYTES_DATA-1:0]    host_wdata,
    output logic [8*NUM_BYTES_DATA-1:0]    host_rdata,
    output logic                           host_ack
);

    localparam int DW    = 8 * NUM_BYTES_DATA;
    localparam int AW    = 8 * NUM_BYTES_ADDRESS;
    localparam int DEPTH = 1 << AW;

    // WAIT cycles between accept and completion. A value of zero means the
    // read completes in the cycle right after the accept.
    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
        $error("uart_mmio_ram: READ_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } rd_state_t;

    logic [DW-1:0] r_mem [DEPTH];

    rd_state_t     r_state;
    rd_state_t     w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_rdy;

    logic [DW-1:0] r_snap;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_host_rdata;
    logic          r_host_ack;

    logic          w_rd_accept;
    logic          w_host_grant;
    logic [DW-1:0] w_rd_word;

    // A controller write always owns the slot. A read accepted in the same
    // cycle as a write to that address slips by one cycle and sees the new
    // data.
    assign w_rd_accept  = !mem_we && mem_re && (r_state == S_IDLE);

    // A host access completes one cycle after its grant. r_host_ack therefore
    // doubles as the "host access pending" flag. This limits the host to one
    // access every two cycles.
    assign w_host_grant = !mem_we && !w_rd_accept && host_req && !r_host_ack;

    // In IDLE the word comes straight from the array, which covers
    // latency 1. In WAIT it comes from the snapshot taken at accept.
    assign w_rd_word = (r_state == S_IDLE) ? r_mem[mem_raddr] : r_snap;

    // Read FSM state and latency counter.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read FSM next-state, counter load/decrement and completion pulse.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_accept) begin
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = (LAT_M1 == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_rdy       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read snapshot, output data registers and host completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap       <= '0;
            r_rdata      <= '0;
            r_host_rdata <= '0;
            r_host_ack   <= 1'b0;
        end else begin
            r_host_ack <= w_host_grant;
            if (w_rd_accept) begin
                r_snap <= r_mem[mem_raddr];
            end
            if (w_state_nxt == S_DONE) begin
                r_rdata <= w_rd_word;
            end
            if (w_host_grant && !host_we) begin
                r_host_rdata <= r_mem[host_addr];
            end
        end
    end

    // Array writes. A controller write takes priority over a host write.
    // Writes are suppressed while reset is asserted.
    // NOTE: the array itself is not reset; only control and output registers
    // are, so the storage can map onto plain RAM without a clear path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                r_mem[mem_waddr] <= mem_wdata;
            end else if (w_host_grant && host_we) begin
                r_mem[host_addr] <= host_wdata;
            end
        end
    end

    assign mem_rdy    = w_rdy;
    assign mem_rdata  = r_rdata;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_uart_mmio_ram.sv
// Self-checking bench for uart_mmio_ram. Three instances with read
// latencies of 1, 2 and 15 are exercised in turn. A select index routes the
// shared stimulus to one instance at a time. Expected values come from a
// word-array reference model and from the latency rules.
module tb_uart_mmio_ram;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_we, mem_re, host_req, host_we;
    logic [7:0]  mem_waddr, mem_raddr, host_addr;
    logic [31:0] mem_wdata, host_wdata;
    logic [31:0] mem_rdata, host_rdata;
    logic        mem_rdy, host_ack;

    int          sel;
    int          lat;
    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] rdata_v  [NDUT];
    logic        rdy_v    [NDUT];
    logic [31:0] hrdata_v [NDUT];
    logic        ack_v    [NDUT];

    logic [31:0] ref_mem [256];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 2 : 15);
        logic sel_k;
        assign sel_k = (sel == k);
        uart_mmio_ram #(
            .NUM_BYTES_DATA   (4),
            .NUM_BYTES_ADDRESS(1),
            .READ_LATENCY     (LAT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_we    (mem_we && sel_k),
            .mem_wdata (mem_wdata),
            .mem_waddr (mem_waddr),
            .mem_re    (mem_re && sel_k),
            .mem_raddr (mem_raddr),
            .mem_rdata (rdata_v[k]),
            .mem_rdy   (rdy_v[k]),
            .host_req  (host_req && sel_k),
            .host_we   (host_we),
            .host_addr (host_addr),
            .host_wdata(host_wdata),
            .host_rdata(hrdata_v[k]),
            .host_ack  (ack_v[k])
        );
    end

    assign mem_rdata  = rdata_v[sel];
    assign mem_rdy    = rdy_v[sel];
    assign host_rdata = hrdata_v[sel];
    assign host_ack   = ack_v[sel];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (L=%0d): observed %h expected %h", tag, lat, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        mem_waddr  = '0;
        mem_raddr  = '0;
        host_addr  = '0;
        mem_wdata  = '0;
        host_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cwrite(input logic [7:0] addr, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_waddr = addr;
        mem_wdata = data;
        tick();
        mem_we = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Tick until mem_rdy is seen or the cycle budget runs out. Any write
    // strobe is dropped after the first edge it is presented on.
    task automatic wait_rdy(inout int n);
        while (!mem_rdy && n < 40) begin
            tick();
            mem_we = 1'b0;
            n++;
        end
    endtask

    // Check a completion: cycle count, data, hold, and single-cycle pulse.
    task automatic finish_read(input string tag, input int n, input int exp_lat,
                               input logic [31:0] exp_data);
        mem_re = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " data"}, mem_rdata, exp_data);
        tick();
        mem_we = 1'b0;
        chk({tag, " pulse"}, {31'b0, mem_rdy}, 32'd0);
        chk({tag, " hold"}, mem_rdata, exp_data);
    endtask

    task automatic cread(input string tag, input logic [7:0] addr);
        int n = 0;
        mem_re    = 1'b1;
        mem_raddr = addr;
        wait_rdy(n);
        finish_read(tag, n, lat, ref_mem[addr]);
    endtask

    task automatic host_op(input string tag, input logic we, input logic [7:0] addr,
                           input logic [31:0] data);
        int n = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = data;
        while (!host_ack && n < 40) begin
            tick();
            n++;
        end
        host_req = 1'b0;
        chk({tag, " ack latency"}, 32'(n), 32'd1);
        if (we) begin
            ref_mem[addr] = data;
        end else begin
            chk({tag, " rdata"}, host_rdata, ref_mem[addr]);
        end
        tick();
        chk({tag, " ack pulse"}, {31'b0, host_ack}, 32'd0);
    endtask

    task automatic run_phase();
        int          n;
        logic [31:0] d;
        logic [7:0]  a;

        // Reset values.
        do_reset();
        chk("reset mem_rdy", {31'b0, mem_rdy}, 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'd0);
        chk("reset host_ack", {31'b0, host_ack}, 32'd0);
        chk("reset host_rdata", host_rdata, 32'd0);

        // Basic write then read.
        cwrite(8'h10, 32'hDEADBEEF);
        cread("basic read", 8'h10);

        // A same-cycle write and read to one address: the read slips one cycle.
        cwrite(8'h20, 32'h0);
        mem_we    = 1'b1;
        mem_waddr = 8'h20;
        mem_wdata = 32'h11111111;
        mem_re    = 1'b1;
        mem_raddr = 8'h20;
        ref_mem[8'h20] = 32'h11111111;
        tick();
        mem_we = 1'b0;
        n = 1;
        wait_rdy(n);
        finish_read("collide read", n, lat + 1, 32'h11111111);

        // Snapshot: a write during WAIT leaves the pending result unchanged.
        cwrite(8'h30, 32'hAAAA0000);
        mem_re    = 1'b1;
        mem_raddr = 8'h30;
        tick();
        n = 1;
        mem_we    = 1'b1;
        mem_waddr = 8'h30;
        mem_wdata = 32'h00005555;
        wait_rdy(n);
        finish_read("snapshot read", n, lat, 32'hAAAA0000);
        ref_mem[8'h30] = 32'h00005555;
        cread("post-snapshot read", 8'h30);

        // A host write is starved by a controller write burst, then granted.
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'hFF;
        host_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            mem_we    = 1'b1;
            mem_waddr = 8'(8'h80 + i);
            mem_wdata = d;
            ref_mem[8'h80 + i] = d;
            tick();
            chk("host starved", {31'b0, host_ack}, 32'd0);
        end
        mem_we = 1'b0;
        tick();
        chk("host ack after burst", {31'b0, host_ack}, 32'd1);
        host_req = 1'b0;
        ref_mem[8'hFF] = 32'hCAFEF00D;
        tick();
        chk("host ack single", {31'b0, host_ack}, 32'd0);
        cread("read host word", 8'hFF);
        cread("read burst word", 8'h82);
        host_op("host read", 1'b0, 8'h10, 32'h0);

        // Back-to-back reads with mem_re held high.
        for (int i = 1; i <= 3; i++) cwrite(8'(i), $urandom);
        mem_re    = 1'b1;
        mem_raddr = 8'h01;
        n = 0;
        wait_rdy(n);
        chk("b2b first latency", 32'(n), 32'(lat));
        chk("b2b data 1", mem_rdata, ref_mem[8'h01]);
        for (int i = 2; i <= 3; i++) begin
            mem_raddr = 8'(i);
            tick();
            n = 1;
            wait_rdy(n);
            chk("b2b spacing", 32'(n), 32'(lat + 1));
            chk("b2b data", mem_rdata, ref_mem[i]);
        end
        mem_re = 1'b0;
        tick();
        chk("b2b end pulse", {31'b0, mem_rdy}, 32'd0);

        // Randomized mix of controller and host traffic over a small pool.
        for (int i = 0; i < 8; i++) cwrite(8'(8'h40 + i), $urandom);
        for (int i = 0; i < 16; i++) begin
            a = 8'(8'h40 + $urandom_range(0, 7));
            d = $urandom;
            case ($urandom_range(0, 3))
                0:       cwrite(a, d);
                1:       cread("rand ctrl read", a);
                2:       host_op("rand host write", 1'b1, a, d);
                default: host_op("rand host read", 1'b0, a, d);
            endcase
        end
        cread("rand final read", 8'h47);

        // Reset during a pending read and a host grant. A write strobed under
        // reset is ignored.
        mem_re    = 1'b1;
        mem_raddr = 8'h10;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h10;
        if (lat > 1) begin
            tick();
        end
        rst = 1'b1;
        tick();
        chk("mid-reset mem_rdy", {31'b0, mem_rdy}, 32'd0);
        chk("mid-reset mem_rdata", mem_rdata, 32'd0);
        chk("mid-reset host_ack", {31'b0, host_ack}, 32'd0);
        chk("mid-reset host_rdata", host_rdata, 32'd0);
        mem_we    = 1'b1;
        mem_waddr = 8'h10;
        mem_wdata = 32'h0BADF00D;
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
        chk("post-reset mem_rdy", {31'b0, mem_rdy}, 32'd0);
        chk("post-reset host_ack", {31'b0, host_ack}, 32'd0);
        cread("post-reset read", 8'h10);
        host_op("post-reset host read", 1'b0, 8'h10, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 0;
        lat = 1;
        idle_inputs();
        for (int p = 0; p < NDUT; p++) begin
            sel = p;
            lat = (p == 0) ? 1 : ((p == 1) ? 2 : 15);
            run_phase();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
